// File: rtl/taylor_ln_seq.sv
// Sequential float32 natural logarithm: x = m*2^e, ln(m) = 2*atanh((m-1)/(m+1)),
// evaluated with one shared adder, multiplier and divider under a small FSM.
module taylor_ln_seq #(
  parameter int N_TERMS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        invalid
);

  localparam logic [31:0] F_ONE     = 32'h3F80_0000;
  localparam logic [31:0] F_NEG_ONE = 32'hBF80_0000;
  localparam logic [31:0] F_LN2     = 32'h3F31_7218;
  localparam logic [31:0] F_QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] F_NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] F_POS_INF = 32'h7F80_0000;
  localparam logic [2:0]  K_LAST    = 3'(N_TERMS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SPEC, S_NUM, S_DEN, S_DIVY, S_SQ, S_POW,
    S_TERM, S_ACC, S_DBL, S_SCALE, S_FIN
  } state_t;

  state_t            state_r;
  logic              busy_r, done_r, invalid_r, spec_inv_r;
  logic [31:0]       out_r, m_r, num_r, den_r, y_r, y2_r, p_r, t_r, acc_r, el_r;
  logic signed [7:0] e_r;
  logic [2:0]        k_r;

  logic        special_s, spec_inv_s;
  logic [31:0] spec_val_s, ef_s;
  logic [31:0] add_a_s, add_b_s, mul_a_s, mul_b_s, div_a_s, div_b_s;
  logic [31:0] add_s, mul_s, div_s;

  // Round-to-nearest-even and range handling shared by all three operators;
  // results too small for a normal are flushed to zero.
  function automatic logic [31:0] fp_pack(input logic sgn, input logic signed [9:0] ex_in,
                                          input logic [22:0] fr, input logic grd,
                                          input logic stk);
    logic [23:0]       rnd;
    logic signed [9:0] ex;
    rnd = {1'b0, fr} + {23'd0, grd & (stk | fr[0])};
    ex  = ex_in + $signed({9'd0, rnd[23]});
    if (ex <= 10'sd0) begin
      return {sgn, 31'd0};
    end else if (ex >= 10'sd255) begin
      return {sgn, 8'hFF, 23'd0};
    end else begin
      return {sgn, ex[7:0], rnd[22:0]};
    end
  endfunction

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (found) begin
        n = n;
      end else if (v[i]) begin
        found = 1'b1;
      end else begin
        n = n + 5'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       big, sml;
    logic [7:0]        d;
    logic [53:0]       shf;
    logic [26:0]       sm, nrm;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic signed [9:0] ex;
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    d   = big[30:23] - sml[30:23];
    shf = {1'b1, sml[22:0], 30'd0} >> d;
    if (d >= 8'd30) begin
      sm = 27'd1;
    end else begin
      sm = shf[53:27] | {26'd0, |shf[26:0]};
    end
    if (big[31] ^ sml[31]) begin
      sum = {2'b01, big[22:0], 3'b000} - {1'b0, sm};
    end else begin
      sum = {2'b01, big[22:0], 3'b000} + {1'b0, sm};
    end
    ex = $signed({2'b00, big[30:23]});
    lz = lzc27(sum[26:0]);
    if (sum[27]) begin
      nrm = sum[27:1] | {26'd0, sum[0]};
      ex  = ex + 10'sd1;
    end else begin
      nrm = sum[26:0] << lz;
      ex  = ex - $signed({5'd0, lz});
    end
    if (a[30:23] == 8'd0) begin
      return b;
    end else if (b[30:23] == 8'd0) begin
      return a;
    end else if (!nrm[26]) begin
      return 32'd0;
    end else begin
      return fp_pack(big[31], ex, nrm[25:3], nrm[2], |nrm[1:0]);
    end
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]       prod;
    logic signed [9:0] ex;
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    ex   = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0)) begin
      return {a[31] ^ b[31], 31'd0};
    end else if (prod[47]) begin
      return fp_pack(a[31] ^ b[31], ex + 10'sd1, prod[46:24], prod[23], |prod[22:0]);
    end else begin
      return fp_pack(a[31] ^ b[31], ex, prod[45:23], prod[22], |prod[21:0]);
    end
  endfunction

  // Divisor is always a nonzero normal here (den in [2,3) or an odd constant).
  function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
    logic [49:0]       dvd, dvs;
    logic [25:0]       q;
    logic              rem;
    logic signed [9:0] ex;
    dvd = {2'b01, a[22:0], 25'd0};
    dvs = {26'd0, 1'b1, b[22:0]};
    q   = 26'(dvd / dvs);
    rem = (({24'd0, q} * dvs) != dvd);
    ex  = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]})
        + (q[25] ? 10'sd127 : 10'sd126);
    if (a[30:23] == 8'd0) begin
      return 32'd0;
    end else if (q[25]) begin
      return fp_pack(a[31] ^ b[31], ex, q[24:2], q[1], q[0] | rem);
    end else begin
      return fp_pack(a[31] ^ b[31], ex, q[23:1], q[0], rem);
    end
  endfunction

  // Exact conversion of the unbiased exponent (|e| <= 127) to float32.
  function automatic logic [31:0] exp_to_fp(input logic signed [7:0] e);
    logic [7:0]  mag;
    logic [2:0]  msb;
    logic [22:0] frac;
    mag = e[7] ? (8'd0 - $unsigned(e)) : $unsigned(e);
    msb = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (mag[i]) begin
        msb = 3'(i);
      end else begin
        msb = msb;
      end
    end
    frac = 23'({15'd0, mag} << (5'd23 - {2'd0, msb}));
    if (e == 8'sd0) begin
      return 32'd0;
    end else begin
      return {e[7], 8'd127 + {5'd0, msb}, frac};
    end
  endfunction

  function automatic logic [31:0] odd_rom(input logic [2:0] k);
    case (k)
      3'd1:    return 32'h4040_0000;
      3'd2:    return 32'h40A0_0000;
      3'd3:    return 32'h40E0_0000;
      3'd4:    return 32'h4110_0000;
      3'd5:    return 32'h4130_0000;
      3'd6:    return 32'h4150_0000;
      3'd7:    return 32'h4170_0000;
      default: return 32'h4040_0000;
    endcase
  endfunction

  assign ef_s  = exp_to_fp(e_r);
  assign add_s = fp_add(add_a_s, add_b_s);
  assign mul_s = fp_mul(mul_a_s, mul_b_s);
  assign div_s = fp_div(div_a_s, div_b_s);

  // Operand decode for inputs that bypass the series.
  always_comb begin
    special_s  = 1'b1;
    spec_val_s = 32'd0;
    spec_inv_s = 1'b0;
    if ((in[30:23] == 8'hFF) && (in[22:0] != 23'd0)) begin
      spec_val_s = F_QNAN;
      spec_inv_s = 1'b1;
    end else if (in[30:23] == 8'h00) begin
      spec_val_s = F_NEG_INF;
    end else if (in[31]) begin
      spec_val_s = F_QNAN;
      spec_inv_s = 1'b1;
    end else if (in[30:23] == 8'hFF) begin
      spec_val_s = F_POS_INF;
    end else begin
      special_s = 1'b0;
    end
  end

  // Steer the shared operators by FSM state.
  always_comb begin
    add_a_s = 32'd0;
    add_b_s = 32'd0;
    mul_a_s = 32'd0;
    mul_b_s = 32'd0;
    div_a_s = 32'd0;
    div_b_s = F_ONE;
    case (state_r)
      S_NUM:   begin add_a_s = m_r;   add_b_s = F_NEG_ONE;     end
      S_DEN:   begin add_a_s = m_r;   add_b_s = F_ONE;         end
      S_DIVY:  begin div_a_s = num_r; div_b_s = den_r;         end
      S_SQ:    begin mul_a_s = y_r;   mul_b_s = y_r;           end
      S_POW:   begin mul_a_s = p_r;   mul_b_s = y2_r;          end
      S_TERM:  begin div_a_s = p_r;   div_b_s = odd_rom(k_r);  end
      S_ACC:   begin add_a_s = acc_r; add_b_s = t_r;           end
      S_DBL:   begin add_a_s = acc_r; add_b_s = acc_r;         end
      S_SCALE: begin mul_a_s = ef_s;  mul_b_s = F_LN2;         end
      S_FIN:   begin add_a_s = acc_r; add_b_s = el_r;          end
      default: begin add_a_s = 32'd0;                          end
    endcase
  end

  // Control FSM and datapath registers; busy rises one edge after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      out_r      <= 32'd0;
      invalid_r  <= 1'b0;
      spec_inv_r <= 1'b0;
      m_r        <= 32'd0;
      e_r        <= 8'sd0;
      num_r      <= 32'd0;
      den_r      <= 32'd0;
      y_r        <= 32'd0;
      y2_r       <= 32'd0;
      p_r        <= 32'd0;
      t_r        <= 32'd0;
      acc_r      <= 32'd0;
      el_r       <= 32'd0;
      k_r        <= 3'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            m_r <= {1'b0, 8'h7F, in[22:0]};
            e_r <= $signed(in[30:23] - 8'd127);
            if (special_s) begin
              acc_r      <= spec_val_s;
              spec_inv_r <= spec_inv_s;
              state_r    <= S_SPEC;
            end else begin
              state_r <= S_NUM;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_SPEC: begin
          out_r     <= acc_r;
          invalid_r <= spec_inv_r;
          done_r    <= 1'b1;
          state_r   <= S_IDLE;
        end
        S_NUM: begin
          num_r   <= add_s;
          busy_r  <= 1'b1;
          state_r <= S_DEN;
        end
        S_DEN: begin
          den_r   <= add_s;
          state_r <= S_DIVY;
        end
        S_DIVY: begin
          y_r     <= div_s;
          acc_r   <= div_s;
          p_r     <= div_s;
          k_r     <= 3'd1;
          state_r <= S_SQ;
        end
        S_SQ: begin
          y2_r    <= mul_s;
          state_r <= S_POW;
        end
        S_POW: begin
          p_r     <= mul_s;
          state_r <= S_TERM;
        end
        S_TERM: begin
          t_r     <= div_s;
          state_r <= S_ACC;
        end
        S_ACC: begin
          acc_r <= add_s;
          if (k_r == K_LAST) begin
            state_r <= S_DBL;
          end else begin
            k_r     <= k_r + 3'd1;
            state_r <= S_POW;
          end
        end
        S_DBL: begin
          acc_r   <= add_s;
          state_r <= S_SCALE;
        end
        S_SCALE: begin
          el_r    <= mul_s;
          state_r <= S_FIN;
        end
        S_FIN: begin
          out_r     <= add_s;
          invalid_r <= 1'b0;
          done_r    <= 1'b1;
          busy_r    <= 1'b0;
          state_r   <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign out     = out_r;
  assign invalid = invalid_r;

endmodule

// File: tb/tb_taylor_ln_seq.sv
// Directed bench for taylor_ln_seq: latency, busy window, exact and ULP-bounded
// results, special operands, ignored restarts and mid-operation reset.
module tb_taylor_ln_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, busy, done, invalid;
  logic [31:0] in_v, out;
  int          n_checks = 0;
  int          n_fails  = 0;
  int          lat, bcyc, seen;

  taylor_ln_seq #(.N_TERMS(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in_v),
    .busy(busy), .done(done), .out(out), .invalid(invalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_ulp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    logic [31:0] diff;
    diff = (obs > exp_v) ? (obs - exp_v) : (exp_v - obs);
    n_checks++;
    assert ((obs[31] === exp_v[31]) && (diff <= 32'd4)) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h within 4 ulp", tag, obs, exp_v);
    end
  endtask

  // Called just after an accept edge; counts edges until done and busy cycles seen.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    while ((done !== 1'b1) && (edges < 64)) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic run_op(input logic [31:0] x, output int edges, output int busy_cnt);
    @(negedge clk);
    start = 1'b1;
    in_v  = x;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(edges, busy_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_v  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out",  out,               32'd0);
    check("rst_inv",  {31'd0, invalid},  32'd0);
    check("rst_busy", {31'd0, busy},     32'd0);
    check("rst_done", {31'd0, done},     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h3F80_0000, lat, bcyc);
    check("one_lat",  32'(lat),  32'd22);
    check("one_busy", 32'(bcyc), 32'd21);
    check("one_out",  out,       32'h0000_0000);
    check("one_inv",  {31'd0, invalid}, 32'd0);
    @(posedge clk); #1;
    check("done_pulse_width", {31'd0, done}, 32'd0);

    run_op(32'h4000_0000, lat, bcyc);
    check("two_lat", 32'(lat), 32'd22);
    check("two_out", out, 32'h3F31_7218);

    run_op(32'h3F00_0000, lat, bcyc);
    check("half_out", out, 32'hBF31_7218);

    run_op(32'h402D_F854, lat, bcyc);
    check_ulp("e_out", out, 32'h3F80_0000);

    run_op(32'h4120_0000, lat, bcyc);
    check_ulp("ten_out", out, 32'h4013_5D8E);
    check("ten_inv", {31'd0, invalid}, 32'd0);

    run_op(32'hBF80_0000, lat, bcyc);
    check("neg_lat",  32'(lat),  32'd1);
    check("neg_busy", 32'(bcyc), 32'd0);
    check("neg_out",  out, 32'h7FC0_0000);
    check("neg_inv",  {31'd0, invalid}, 32'd1);

    run_op(32'h0000_0000, lat, bcyc);
    check("zero_lat", 32'(lat), 32'd1);
    check("zero_out", out, 32'hFF80_0000);
    check("zero_inv", {31'd0, invalid}, 32'd0);

    run_op(32'h7F80_0000, lat, bcyc);
    check("inf_out", out, 32'h7F80_0000);

    run_op(32'h0000_0001, lat, bcyc);
    check("denorm_out", out, 32'hFF80_0000);

    run_op(32'h7F80_0001, lat, bcyc);
    check("nan_out", out, 32'h7FC0_0000);
    check("nan_inv", {31'd0, invalid}, 32'd1);

    // A start pulse during a running operation must be ignored.
    @(negedge clk);
    start = 1'b1;
    in_v  = 32'h4000_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    in_v  = 32'h4120_0000;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_mid", {31'd0, busy}, 32'd1);
    wait_done(lat, bcyc);
    check("ignore_lat", 32'(lat), 32'd17);
    check("ignore_out", out, 32'h3F31_7218);

    // Start raised in the cycle done is high is accepted.
    start = 1'b1;
    in_v  = 32'h3F00_0000;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bcyc);
    check("b2b_lat", 32'(lat), 32'd22);
    check("b2b_out", out, 32'hBF31_7218);

    // Reset in the middle of an operation aborts it.
    @(negedge clk);
    start = 1'b1;
    in_v  = 32'h4120_0000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_out",  out,              32'd0);
    check("abort_busy", {31'd0, busy},    32'd0);
    check("abort_done", {31'd0, done},    32'd0);
    check("abort_inv",  {31'd0, invalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    run_op(32'h4000_0000, lat, bcyc);
    check("post_rst_lat", 32'(lat), 32'd22);
    check("post_rst_out", out, 32'h3F31_7218);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
